weight_fetch_biu: RTL and testbench
===================================

Name: weight_fetch_biu

Overview:
- Weight-side bus interface unit sitting directly upstream of the ICB arbiter (weight requester port).
- On a start pulse it fetches LEN consecutive 32-bit words from BASE_ADDR through the arbiter's req/vld/rdy command channel.
- It collects the read responses into an internal FIFO and streams them to the PE-array weight loader over a valid/ready interface.
- A credit scheme guarantees FIFO space for every outstanding read, because the arbiter's response valid is not back-pressurable.

Parameters:
FIFO_DEPTH, 8, weight FIFO entries; power of 2, minimum 4
LEN_W, 16, width of transfer length
PTR_W, 3, log2(FIFO_DEPTH)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  single-cycle fetch request; honoured only in IDLE
base_addr  in  32  byte address of first word; bits [1:0] ignored and forced to 0
len  in  LEN_W  number of words to fetch
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after last word has been pushed into the FIFO
weight_biu2arb_req  out  1  bus ownership request to arbiter
weight_biu2arb_addr  out  32  read address
weight_biu2arb_vld  out  1  command valid
weight_biu2arb_rdy  in  1  arbiter grant / command ready
arb2weight_biu_data  in  32  read data
arb2weight_biu_vld  in  1  read data valid
arb2weight_biu_rdy  out  1  response ready
wt_data  out  32  FIFO head word to weight loader
wt_vld  out  1  FIFO not empty
wt_rdy  in  1  weight loader accepts wt_data

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; all counters/pointers=0; req=0, vld=0, addr=0, arb rdy=0, done=0, busy=0, wt_vld=0, wt_data=0; FIFO contents discarded. Reset mid-transfer aborts with no done pulse.
- Command handshake: a command is issued in a cycle where vld=1 and rdy=1. Response handshake: a response is accepted in a cycle where arb2weight_biu_vld=1.
- States:
  - IDLE: start=1 latches base_addr (forced word-aligned) and len. If len=0, go to DONE with req never asserted; else go to FETCH. start in any other state is ignored.
  - FETCH: req=1; arb2weight_biu_rdy=1. vld=1 when issued_cnt<len and outstanding+fifo_count<FIFO_DEPTH. Each issued command: addr+=4 (mod 2^32, wraps silently), issued_cnt++. When the final command issues, go to WAIT_RSP.
  - WAIT_RSP: req=1, vld=0, rdy=1. When the response that makes rcvd_cnt==len arrives, go to DONE; req drops in the following cycle.
  - DONE: done=1 for one cycle, req=0; next state is IDLE. FIFO may still hold data.
- weight_biu2arb_addr is registered and holds the next address to issue. It is stable while vld=1 and rdy=0.
- outstanding = issued_cnt - rcvd_cnt. Simultaneous issue and response in one cycle leaves it unchanged.
- Data loss is impossible: responses are never refused, and the credit rule bounds outstanding+fifo_count by FIFO_DEPTH.
- An unexpected response (vld while no reads are outstanding) is dropped and not pushed.
- FIFO:
  - Push on response; pop on wt_vld&wt_rdy.
  - Simultaneous push and pop in one cycle leaves the count unchanged. Push while empty with pop is not possible.
  - wt_data is the FIFO head and is valid in the cycle after push (one-cycle latency from arb vld to wt_vld).
  - Pointers wrap modulo FIFO_DEPTH; count is PTR_W+1 bits.
- The weight loader may stall indefinitely. Issue stalls once the credit is exhausted and resumes the cycle after a pop frees a slot.

Optional Feature:
- Macro WEIGHT_FETCH_PERF_EN.
- Defined: adds output fetch_cycles [31:0]. It clears when start is honoured and increments every cycle in FETCH or WAIT_RSP, saturating at 0xFFFFFFFF. It holds its value after DONE until the next start; reset value 0.
- Undefined: port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Basic fetch: base_addr=0x1000_0000, len=4, rdy=1, one-cycle response latency, wt_rdy=1 -> addrs 0x1000_0000/04/08/0C issued, 4 words out in order, one done pulse, req low after done.
- Zero length: start with len=0 -> done pulses 2 cycles after start, req/vld never asserted.
- Back-pressure: len=20, wt_rdy=0 -> exactly 8 commands issued then vld stays 0. Then wt_rdy=1 -> remaining 12 issued, all 20 words received intact, no overflow.
- Grant delay: rdy held 0 for 5 cycles after req -> vld=1 with addr stable at base, no issue counted until rdy=1.
- Address wrap and misalignment: base_addr=0xFFFF_FFFB, len=3 -> addrs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Robustness: start during FETCH -> ignored. rst_n=0 mid-transfer -> all outputs reset values next cycle, no done. Then a new len=2 fetch completes normally.

Source files
------------

// File: rtl/weight_fetch_biu_if.sv
// Bus bundle for weight_fetch_biu: arbiter command/response channels and the weight loader stream.
// master = the BIU side, slave = the arbiter/loader side.
interface weight_fetch_biu_if;
    logic        weight_biu2arb_req;
    logic [31:0] weight_biu2arb_addr;
    logic        weight_biu2arb_vld;
    logic        weight_biu2arb_rdy;
    logic [31:0] arb2weight_biu_data;
    logic        arb2weight_biu_vld;
    logic        arb2weight_biu_rdy;
    logic [31:0] wt_data;
    logic        wt_vld;
    logic        wt_rdy;

    modport master (
        output weight_biu2arb_req, weight_biu2arb_addr, weight_biu2arb_vld,
        input  weight_biu2arb_rdy,
        input  arb2weight_biu_data, arb2weight_biu_vld,
        output arb2weight_biu_rdy,
        output wt_data, wt_vld,
        input  wt_rdy
    );

    modport slave (
        input  weight_biu2arb_req, weight_biu2arb_addr, weight_biu2arb_vld,
        output weight_biu2arb_rdy,
        output arb2weight_biu_data, arb2weight_biu_vld,
        input  arb2weight_biu_rdy,
        input  wt_data, wt_vld,
        output wt_rdy
    );
endinterface

// File: rtl/weight_fetch_biu.sv
// Weight-side bus interface unit: credit-limited burst read through the ICB arbiter into a FIFO.
// Optional macro WEIGHT_FETCH_PERF_EN adds the fetch_cycles performance counter output.
module weight_fetch_biu #(
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 16,
    parameter int PTR_W      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    weight_fetch_biu_if.master bus
`ifdef WEIGHT_FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_cycles
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT_RSP, DONE} state_t;

    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  issued_q, issued_d;
    logic [LEN_W-1:0]  rcvd_q, rcvd_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [31:0]       mem_d [FIFO_DEPTH];
    logic              done_q, done_d;

    logic [LEN_W-1:0]  outstanding;
    logic [LEN_W:0]    credit_used;
    logic              active, cmd_vld, issue, push, pop, fifo_vld;

    // Credit: every in-flight read already owns a FIFO slot, so responses never need back-pressure.
    assign outstanding = issued_q - rcvd_q;
    assign credit_used = {1'b0, outstanding} + (LEN_W+1)'(count_q);
    assign active      = (state_q == FETCH) || (state_q == WAIT_RSP);
    assign cmd_vld     = (state_q == FETCH) && (issued_q < len_q) &&
                         (credit_used < (LEN_W+1)'(FIFO_DEPTH));
    assign issue       = cmd_vld && bus.weight_biu2arb_rdy;
    assign push        = bus.arb2weight_biu_vld && (outstanding != '0);
    assign fifo_vld    = (count_q != '0);
    assign pop         = fifo_vld && bus.wt_rdy;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        issued_d = issued_q;
        rcvd_d   = rcvd_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        done_d   = (state_q == DONE);

        if (issue) begin
            addr_d   = addr_q + 32'd4;
            issued_d = issued_q + LEN_W'(1);
        end
        if (push) begin
            rcvd_d          = rcvd_q + LEN_W'(1);
            mem_d[wr_ptr_q] = bus.arb2weight_biu_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = base_addr & 32'hFFFF_FFFC;
                    len_d    = len;
                    issued_d = '0;
                    rcvd_d   = '0;
                    state_d  = (len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (issue && ((issued_q + LEN_W'(1)) == len_q)) state_d = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (push && ((rcvd_q + LEN_W'(1)) == len_q)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            rcvd_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            rcvd_q   <= rcvd_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            done_q   <= done_d;
            mem_q    <= mem_d;
        end
    end

    assign busy                    = (state_q != IDLE);
    assign done                    = done_q;
    assign bus.weight_biu2arb_req  = active;
    assign bus.weight_biu2arb_addr = addr_q;
    assign bus.weight_biu2arb_vld  = cmd_vld;
    assign bus.arb2weight_biu_rdy  = active;
    assign bus.wt_vld              = fifo_vld;
    assign bus.wt_data             = mem_q[rd_ptr_q];

`ifdef WEIGHT_FETCH_PERF_EN
    logic [31:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if ((state_q == IDLE) && start) cyc_d = '0;
        else if (active && (cyc_q != 32'hFFFF_FFFF)) cyc_d = cyc_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cyc_q <= '0;
        else        cyc_q <= cyc_d;
    end

    assign fetch_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_weight_fetch_biu.sv
// Directed, table-driven bench for weight_fetch_biu with a one-cycle-latency arbiter model.
// Build with WEIGHT_FETCH_PERF_EN to also connect the fetch_cycles port.
module tb_weight_fetch_biu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
`ifdef WEIGHT_FETCH_PERF_EN
    logic [31:0] fetch_cycles;
`endif

    weight_fetch_biu_if bus();

    weight_fetch_biu #(.FIFO_DEPTH(8), .LEN_W(16), .PTR_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
`ifdef WEIGHT_FETCH_PERF_EN
        ,
        .fetch_cycles (fetch_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] base;
        int          len;
        int          grant_delay;
        int          stall;
        int          restart_at;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        int          exp_stall_cmds;
    } vec_t;

    vec_t        vecs [5];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] cmd_addrs [$];
    logic [31:0] got_q [$];
    int          done_cnt;
    int          req_cycles;
    int          vld_cycles;
    logic        pend_vld;
    logic [31:0] pend_data;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [31:0] b, input logic [15:0] l);
        start     = s;
        base_addr = b;
        len       = l;
    endtask

    // One clock: present arbiter/loader inputs, observe handshakes, advance to the next negedge.
    task automatic cycleStep(input logic grant, input logic loader_rdy);
        logic        nxt_vld;
        logic [31:0] nxt_data;
        bus.arb2weight_biu_vld  = pend_vld;
        bus.arb2weight_biu_data = pend_vld ? pend_data : 32'hDEAD_BEEF;
        bus.weight_biu2arb_rdy  = grant;
        bus.wt_rdy              = loader_rdy;
        #1;
        nxt_vld  = bus.weight_biu2arb_vld && grant;
        nxt_data = memWord(bus.weight_biu2arb_addr);
        if (nxt_vld) cmd_addrs.push_back(bus.weight_biu2arb_addr);
        if (bus.wt_vld && loader_rdy) got_q.push_back(bus.wt_data);
        if (done) done_cnt++;
        if (bus.weight_biu2arb_req) req_cycles++;
        if (bus.weight_biu2arb_vld) vld_cycles++;
        pend_vld  = nxt_vld;
        pend_data = nxt_data;
        @(negedge clk);
    endtask

    task automatic runFetch(input vec_t v, input string tag);
        logic [31:0] aligned;
        int          hold_bad;
        int          stall_cmds;
        logic        stall_vld;
        int          addr_bad;
        int          data_bad;
        logic        finished;
        aligned    = v.base & 32'hFFFF_FFFC;
        cmd_addrs.delete();
        got_q.delete();
        done_cnt   = 0;
        hold_bad   = 0;
        stall_cmds = -1;
        stall_vld  = 1'b1;
        finished   = 1'b0;
        applyStimulus(1'b1, v.base, 16'(v.len));
        cycleStep(1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 16'h0);
        for (int c = 0; c < 600 && !finished; c++) begin
            if (c < v.grant_delay &&
                (bus.weight_biu2arb_vld !== 1'b1 || bus.weight_biu2arb_addr !== aligned)) hold_bad++;
            if (c == v.stall && v.stall > 0) begin
                stall_cmds = cmd_addrs.size();
                stall_vld  = bus.weight_biu2arb_vld;
            end
            if (c == v.restart_at) applyStimulus(1'b1, 32'h3000_0000, 16'd1);
            cycleStep(c >= v.grant_delay, c >= v.stall);
            if (c == v.restart_at) applyStimulus(1'b0, 32'h0, 16'h0);
            if (done_cnt > 0 && got_q.size() >= v.len && c >= v.stall) finished = 1'b1;
        end
        checkOutput({tag, "_completed"}, 32'(finished), 32'd1);
        for (int k = 0; k < 3; k++) cycleStep(1'b1, 1'b1);
        checkOutput({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        checkOutput({tag, "_req_after_done"}, 32'(bus.weight_biu2arb_req), 32'd0);
        checkOutput({tag, "_busy_after_done"}, 32'(busy), 32'd0);
        checkOutput({tag, "_cmd_count"}, 32'(cmd_addrs.size()), 32'(v.len));
        checkOutput({tag, "_word_count"}, 32'(got_q.size()), 32'(v.len));
        checkOutput({tag, "_first_addr"}, (cmd_addrs.size() > 0) ? cmd_addrs[0] : 32'hxxxx_xxxx, v.exp_first);
        checkOutput({tag, "_last_addr"},
                    (cmd_addrs.size() > 0) ? cmd_addrs[cmd_addrs.size()-1] : 32'hxxxx_xxxx, v.exp_last);
        addr_bad = 0;
        data_bad = 0;
        for (int i = 0; i < v.len; i++) begin
            if (i >= cmd_addrs.size() || cmd_addrs[i] !== aligned + 32'(4*i)) addr_bad++;
            if (i >= got_q.size() || got_q[i] !== memWord(aligned + 32'(4*i))) data_bad++;
        end
        checkOutput({tag, "_addr_seq_errors"}, 32'(addr_bad), 32'd0);
        checkOutput({tag, "_data_seq_errors"}, 32'(data_bad), 32'd0);
        if (v.stall > 0) begin
            checkOutput({tag, "_cmds_while_stalled"}, 32'(stall_cmds), 32'(v.exp_stall_cmds));
            checkOutput({tag, "_vld_when_credit_out"}, 32'(stall_vld), 32'd0);
        end
        if (v.grant_delay > 0) checkOutput({tag, "_hold_during_grant_delay"}, 32'(hold_bad), 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'h1000_0000,  4, 0,  0, -1, 32'h1000_0000, 32'h1000_000C, 0};
        vecs[1] = '{32'hFFFF_FFFB,  3, 0,  0, -1, 32'hFFFF_FFF8, 32'h0000_0000, 0};
        vecs[2] = '{32'h2000_0100, 20, 0, 30, -1, 32'h2000_0100, 32'h2000_014C, 8};
        vecs[3] = '{32'h0000_8000,  6, 5,  0, -1, 32'h0000_8000, 32'h0000_8014, 0};
        vecs[4] = '{32'h2000_0000,  4, 0,  0,  2, 32'h2000_0000, 32'h2000_000C, 0};

        rst_n     = 1'b0;
        pend_vld  = 1'b0;
        pend_data = '0;
        applyStimulus(1'b0, 32'h0, 16'h0);
        bus.weight_biu2arb_rdy  = 1'b0;
        bus.arb2weight_biu_vld  = 1'b0;
        bus.arb2weight_biu_data = '0;
        bus.wt_rdy              = 1'b0;
        @(negedge clk);
        cycleStep(1'b0, 1'b0);
        cycleStep(1'b0, 1'b0);
        checkOutput("reset_ctrl", 32'({bus.weight_biu2arb_req, bus.weight_biu2arb_vld,
                    bus.arb2weight_biu_rdy, done, busy, bus.wt_vld}), 32'd0);
        checkOutput("reset_addr", bus.weight_biu2arb_addr, 32'h0);
        checkOutput("reset_wt_data", bus.wt_data, 32'h0);
        rst_n = 1'b1;
        cycleStep(1'b0, 1'b1);

        for (int i = 0; i < 5; i++) runFetch(vecs[i], $sformatf("vec%0d", i));

        // Zero length: done two edges after start, no bus activity at all.
        begin
            logic [3:0] pattern;
            req_cycles = 0;
            vld_cycles = 0;
            pattern    = '0;
            applyStimulus(1'b1, 32'h1234_5678, 16'd0);
            for (int c = 0; c < 4; c++) begin
                done_cnt = 0;
                cycleStep(1'b1, 1'b1);
                if (c == 0) applyStimulus(1'b0, 32'h0, 16'h0);
                pattern[c] = (done_cnt != 0);
            end
            checkOutput("zero_len_done_timing", 32'(pattern), 32'h4);
            checkOutput("zero_len_req_cycles", 32'(req_cycles), 32'd0);
            checkOutput("zero_len_vld_cycles", 32'(vld_cycles), 32'd0);
        end

        // Reset in the middle of a transfer, with a stray response arriving afterwards.
        done_cnt = 0;
        applyStimulus(1'b1, 32'h4000_0000, 16'd16);
        cycleStep(1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 16'h0);
        for (int c = 0; c < 5; c++) cycleStep(1'b1, 1'b0);
        checkOutput("midrst_fifo_filled", 32'(bus.wt_vld), 32'd1);
        rst_n = 1'b0;
        cycleStep(1'b1, 1'b0);
        rst_n = 1'b1;
        checkOutput("midrst_ctrl", 32'({bus.weight_biu2arb_req, bus.weight_biu2arb_vld,
                    bus.arb2weight_biu_rdy, done, busy, bus.wt_vld}), 32'd0);
        checkOutput("midrst_addr", bus.weight_biu2arb_addr, 32'h0);
        checkOutput("midrst_wt_data", bus.wt_data, 32'h0);
        for (int c = 0; c < 4; c++) cycleStep(1'b1, 1'b0);
        checkOutput("midrst_stray_rsp_dropped", 32'(bus.wt_vld), 32'd0);
        checkOutput("midrst_no_done", 32'(done_cnt), 32'd0);
        runFetch('{32'h5000_0004, 2, 0, 0, -1, 32'h5000_0004, 32'h5000_0008, 0}, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
